vga_sync_out: RTL and testbench
===============================

# vga_sync_out

Downstream stage of the horizontal/vertical pixel counters in the 640x480@60 VGA path. Samples the raw `h_count`/`v_count` values and the line-end enable, and produces registered, latency-aligned monitor timing: active-low sync pulses, a display-enable, clamped pixel coordinates, and line/frame strobes. A configurable delay line aligns these outputs with pixel-memory read latency. A sticky checker flags counter values that are out of range or out of sequence.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch
- `PIPE_DELAY`, 2, output latency in clocks; legal range 1..4
- `clk_25Hz` input 1: pixel clock (25 MHz despite the name); everything is on its rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `h_count` input 16: horizontal count, 0..H_TOTAL-1
- `v_count` input 16: vertical count, 0..V_TOTAL-1
- `enable_v_counter` input 1: high for exactly the clock where `h_count`=H_TOTAL-1
- `hsync` output 1: active-low horizontal sync
- `vsync` output 1: active-low vertical sync
- `video_on` output 1: high in the visible region
- `pixel_x` output 10: visible column; 0 when `video_on`=0
- `pixel_y` output 10: visible row; 0 when `video_on`=0
- `line_start` output 1: one-clock pulse at `h_count`=0
- `frame_start` output 1: one-clock pulse at `h_count`=0 and `v_count`=0
- `count_error` output 1: sticky; cleared only by reset

## Operation
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800 by default).
  - V_TOTAL = sum of the four V parameters (525 by default).
- Stage 0 (registered) decodes each axis into one of four regions: VIS, FP, SYNC, BP.
- Horizontal regions, for H = `h_count`:
  - VIS: H < H_VISIBLE.
  - FP: H_VISIBLE ≤ H < H_VISIBLE+H_FRONT.
  - SYNC: the next H_SYNC values (656..751 by default).
  - BP: the remainder.
- Vertical regions use the same scheme (SYNC = lines 490..491 by default).
- Stage-0 outputs:
  - `hsync_n` = !(H region==SYNC); `vsync_n` = !(V region==SYNC).
  - `video_on` = both regions are VIS.
  - `pixel_x`/`pixel_y` = low 10 bits of the counts when `video_on`=1, otherwise 0.
  - Strobes are decoded as described in the port list.
- Stage 0 feeds a shift register of PIPE_DELAY-1 further stages. The last stage drives the ports.
- Sequence checker holds the previous `h_count`, `v_count` and a `prev_valid` flag. Set `count_error` when any of the following holds:
  - `h_count` ≥ H_TOTAL or `v_count` ≥ V_TOTAL.
  - `prev_valid`=1 and `h_count` ≠ (prev_h+1) mod H_TOTAL.
  - `v_count` changes when prev_h ≠ H_TOTAL-1.
  - `v_count` changes by anything other than +1 mod V_TOTAL.
  - `enable_v_counter`=1 while `h_count` ≠ H_TOTAL-1.
- `prev_valid` is 0 out of reset and becomes 1 after the first sampled clock. The first post-reset sample is never flagged as a sequence error, only as a range error.
- Out-of-range counts:
  - Decode as blanking: both regions BP, syncs inactive, `video_on`=0.
  - They never assert the strobes.
- All region comparisons use the full 16-bit inputs. The pixel outputs truncate to 10 bits only after the VIS qualification.

## Timing
- Latency: count sample at edge N → ports update at edge N+PIPE_DELAY-1 after the sampling edge. The total is PIPE_DELAY clocks from input to output.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (asynchronous assert, deassert on any edge) forces every pipeline stage to blanking:
  - `hsync`=1, `vsync`=1.
  - `video_on`=0, `pixel_x`=0, `pixel_y`=0.
  - `line_start`=0, `frame_start`=0.
  - `count_error`=0, `prev_valid`=0.
- Reset mid-frame:
  - Outputs go to their reset values immediately.
  - On release, the pipeline refills with decoded values after PIPE_DELAY clocks, with no stale data emitted.
- Boundary cases:
  - `h_count`=799 with `v_count`=524 → next sample 0/0 is legal.
  - `frame_start` and `line_start` assert together at that point.
- `count_error` asserts PIPE_DELAY clocks after the offending sample, aligned with the other outputs.

## Structure
- Shared package `vga_pkg`:
  - Region enum {VIS, FP, SYNC, BP}.
  - Default 640x480 timing constants.
  - H_TOTAL/V_TOTAL derivation.
- One sub-module, `vga_axis_decode`:
  - Parameterised by VISIBLE/FRONT/SYNC/BACK.
  - Returns the region and a sync flag for one axis.
  - Instantiated once per axis.
- Delay line and checker stay in the top module.

## Test plan
- Reset held low, clocks running → `hsync`=1, `vsync`=1, `video_on`=0, `count_error`=0; after release, the first decoded output appears exactly PIPE_DELAY clocks later.
- Full frame from an ideal counter model (PIPE_DELAY=2):
  - `hsync` low for 96 clocks starting when h=656 is output.
  - `vsync` low for 2 lines (490..491).
  - 640×480 `video_on` clocks per frame.
  - `count_error`=0.
- Corner h=799,v=524 → 0,0 → `line_start`=1 and `frame_start`=1 for one clock with `pixel_x`=0, `pixel_y`=0, `video_on`=1.
- Inject `h_count` jump 100→102 → `count_error`=1 two clocks later and stays 1 for the remainder of the frame.
- Drive `v_count`=600 → `count_error`=1, `vsync`=1, `video_on`=0, no strobes.
- Assert reset at h=300,v=200, release at h=310 → outputs at reset values immediately; valid decode of h=311 appears PIPE_DELAY clocks after release with no spurious `count_error`.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 640x480@60 VGA timing output path.
//   - region_e    : which part of a line/frame an axis count falls in
//   - DEF_*       : default 640x480@60 timing constants
//   - axis_total  : total counts per axis (visible + porches + sync)
//   - vga_out_t   : one pipeline stage worth of monitor timing outputs
//   - VGA_BLANK   : blanking value of a stage (syncs inactive, everything off)
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    RGN_VIS  = 2'd0,
    RGN_FP   = 2'd1,
    RGN_SYNC = 2'd2,
    RGN_BP   = 2'd3
  } region_e;

  // Default 640x480@60 timing (25 MHz pixel clock)
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync_len, input int back);
    return visible + front + sync_len + back;
  endfunction

  // Sync fields are stored active-low, exactly as they leave the block.
  typedef struct packed {
    logic       hsync_n;
    logic       vsync_n;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic       count_error;
  } vga_out_t;

  localparam vga_out_t VGA_BLANK = '{
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    video_on:    1'b0,
    pixel_x:     10'd0,
    pixel_y:     10'd0,
    line_start:  1'b0,
    frame_start: 1'b0,
    count_error: 1'b0
  };

endpackage

// File: rtl/vga_axis_decode.sv
// -----------------------------------------------------------------------------
// vga_axis_decode
// Combinational region decode for one timing axis (horizontal or vertical).
// Layout along the axis: VISIBLE, FRONT porch, SYNC pulse, BACK porch.
//
// Ports:
//   count       in  16  raw axis count
//   region      out     region the count falls in; counts past the end of
//                       the axis land in RGN_BP
//   sync_active out  1  count is inside the sync pulse
//   in_range    out  1  count < VISIBLE+FRONT+SYNC+BACK
// -----------------------------------------------------------------------------
module vga_axis_decode
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic [15:0] count,
  output region_e     region,
  output logic        sync_active,
  output logic        in_range
);

  // Region boundaries, sized to the count so every compare uses all 16 bits.
  localparam logic [15:0] FP_START   = 16'(VISIBLE);
  localparam logic [15:0] SYNC_START = 16'(VISIBLE + FRONT);
  localparam logic [15:0] BP_START   = 16'(VISIBLE + FRONT + SYNC);
  localparam logic [15:0] TOTAL      = 16'(axis_total(VISIBLE, FRONT, SYNC, BACK));

  always_comb begin
    region = RGN_BP;
    if (count < FP_START) begin
      region = RGN_VIS;
    end else if (count < SYNC_START) begin
      region = RGN_FP;
    end else if (count < BP_START) begin
      region = RGN_SYNC;
    end
  end

  assign sync_active = (region == RGN_SYNC);
  assign in_range    = (count < TOTAL);

endmodule

// File: rtl/vga_sync_out.sv
// -----------------------------------------------------------------------------
// vga_sync_out
// Turns raw h/v pixel counter values into registered, latency-aligned monitor
// timing, and watches the counters for out-of-range / out-of-sequence values.
//
// Stage 0 registers the decoded timing of the current sample; PIPE_DELAY-1
// further stages delay it so the ports line up with pixel-memory read data.
// A sample taken at edge N reaches the ports at edge N+PIPE_DELAY-1.
//
// Ports:
//   clk_25Hz          in   1  pixel clock (25 MHz), rising edge
//   reset_n           in   1  asynchronous active-low reset
//   h_count           in  16  horizontal count, 0..H_TOTAL-1
//   v_count           in  16  vertical count, 0..V_TOTAL-1
//   enable_v_counter  in   1  high only while h_count = H_TOTAL-1
//   hsync             out  1  active-low horizontal sync
//   vsync             out  1  active-low vertical sync
//   video_on          out  1  both axes in their visible region
//   pixel_x           out 10  visible column, 0 outside the visible area
//   pixel_y           out 10  visible row, 0 outside the visible area
//   line_start        out  1  one-clock pulse for h_count = 0
//   frame_start       out  1  one-clock pulse for h_count = 0, v_count = 0
//   count_error       out  1  sticky counter fault flag, cleared by reset only
// -----------------------------------------------------------------------------
module vga_sync_out
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIPE_DELAY = 2            // legal range 1..4
) (
  input  logic        clk_25Hz,
  input  logic        reset_n,
  input  logic [15:0] h_count,
  input  logic [15:0] v_count,
  input  logic        enable_v_counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        count_error
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

  // Out-of-range settings are pulled back into 1..4 rather than producing an
  // empty or oversized delay line.
  localparam int PD = (PIPE_DELAY < 1) ? 1 : ((PIPE_DELAY > 4) ? 4 : PIPE_DELAY);

  // ---------------------------------------------------------------------------
  // Axis decode
  // ---------------------------------------------------------------------------
  region_e h_region;
  region_e v_region;
  logic    h_sync_active;
  logic    v_sync_active;
  logic    h_in_range;
  logic    v_in_range;
  logic    any_out_of_range;

  vga_axis_decode #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_decode (
    .count       (h_count),
    .region      (h_region),
    .sync_active (h_sync_active),
    .in_range    (h_in_range)
  );

  vga_axis_decode #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_decode (
    .count       (v_count),
    .region      (v_region),
    .sync_active (v_sync_active),
    .in_range    (v_in_range)
  );

  assign any_out_of_range = !h_in_range || !v_in_range;

  // ---------------------------------------------------------------------------
  // Sequence checker
  // ---------------------------------------------------------------------------
  logic [15:0] prev_h;
  logic [15:0] prev_v;
  logic        prev_valid;
  logic        err_sticky_q;

  logic [15:0] h_expected;
  logic [15:0] v_expected;
  logic        v_changed;
  logic        seq_error;
  logic        err_now;

  // A previous count that was itself out of range simply increments here
  // instead of wrapping; that sample already latched the sticky error, so the
  // difference never reaches the output.
  assign h_expected = (prev_h == H_LAST) ? 16'd0 : prev_h + 16'd1;
  assign v_expected = (prev_v == V_LAST) ? 16'd0 : prev_v + 16'd1;
  assign v_changed  = (v_count != prev_v);

  // The first sample after reset has no history, so only the range test
  // applies to it.
  always_comb begin
    seq_error = 1'b0;
    if (prev_valid) begin
      if (h_count != h_expected) begin
        seq_error = 1'b1;
      end
      if (v_changed && (prev_h != H_LAST)) begin
        seq_error = 1'b1;
      end
      if (v_changed && (v_count != v_expected)) begin
        seq_error = 1'b1;
      end
      if (enable_v_counter && (h_count != H_LAST)) begin
        seq_error = 1'b1;
      end
    end
  end

  assign err_now = any_out_of_range || seq_error;

  always_ff @(posedge clk_25Hz or negedge reset_n) begin
    if (!reset_n) begin
      prev_h       <= '0;
      prev_v       <= '0;
      prev_valid   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      prev_h       <= h_count;
      prev_v       <= v_count;
      prev_valid   <= 1'b1;
      err_sticky_q <= err_sticky_q || err_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-0 decode
  // ---------------------------------------------------------------------------
  vga_out_t stage0_d;

  always_comb begin
    stage0_d = VGA_BLANK;
    // Out-of-range counts stay fully blanked: no sync, no video, no strobes.
    if (!any_out_of_range) begin
      stage0_d.hsync_n     = !h_sync_active;
      stage0_d.vsync_n     = !v_sync_active;
      stage0_d.video_on    = (h_region == RGN_VIS) && (v_region == RGN_VIS);
      stage0_d.line_start  = (h_count == 16'd0);
      stage0_d.frame_start = (h_count == 16'd0) && (v_count == 16'd0);
      // Truncate only after the visible qualification has used all 16 bits.
      if (stage0_d.video_on) begin
        stage0_d.pixel_x = h_count[9:0];
        stage0_d.pixel_y = v_count[9:0];
      end
    end
    // The error bit rides the pipeline so it appears aligned with the
    // offending sample; folding in the sticky flag keeps it high afterwards.
    stage0_d.count_error = err_sticky_q || err_now;
  end

  // ---------------------------------------------------------------------------
  // Delay line: pipe_q[0] is stage 0, pipe_q[PD-1] drives the ports.
  // ---------------------------------------------------------------------------
  vga_out_t pipe_q [PD];

  always_ff @(posedge clk_25Hz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PD; i++) begin
        pipe_q[i] <= VGA_BLANK;
      end
    end else begin
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < PD; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign hsync       = pipe_q[PD-1].hsync_n;
  assign vsync       = pipe_q[PD-1].vsync_n;
  assign video_on    = pipe_q[PD-1].video_on;
  assign pixel_x     = pipe_q[PD-1].pixel_x;
  assign pixel_y     = pipe_q[PD-1].pixel_y;
  assign line_start  = pipe_q[PD-1].line_start;
  assign frame_start = pipe_q[PD-1].frame_start;
  assign count_error = pipe_q[PD-1].count_error;

endmodule

// File: tb/tb_vga_sync_out.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_out
// Self-checking bench for vga_sync_out (640x480@60 defaults, PIPE_DELAY = 2).
// A timing model computes the required port values directly from the monitor
// timing rules (plain arithmetic on h/v); a compare process checks the DUT
// against it every falling edge. Directed scenarios add hand-computed checks.
// -----------------------------------------------------------------------------
module tb_vga_sync_out;

  localparam int PD = 2;

  // Bench-side timing numbers, written out independently of the RTL package.
  localparam int HT = 800;
  localparam int VT = 525;

  // {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, error}
  localparam int W = 26;
  localparam logic [W-1:0] BLANK = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_25Hz = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] h_count  = '0;
  logic [15:0] v_count  = '0;
  logic        enable_v_counter = 1'b0;

  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        line_start;
  logic        frame_start;
  logic        count_error;

  always #5 clk_25Hz = ~clk_25Hz;

  vga_sync_out #(
    .PIPE_DELAY (PD)
  ) dut (
    .clk_25Hz         (clk_25Hz),
    .reset_n          (reset_n),
    .h_count          (h_count),
    .v_count          (v_count),
    .enable_v_counter (enable_v_counter),
    .hsync            (hsync),
    .vsync            (vsync),
    .video_on         (video_on),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .line_start       (line_start),
    .frame_start      (frame_start),
    .count_error      (count_error)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Timing model
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] model_out(input int h, input int v, input logic err);
    logic       in_r;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] px;
    logic [9:0] py;
    logic       ls;
    logic       fs;
    in_r = (h < HT) && (v < VT);
    hs   = !(in_r && h >= 656 && h < 752);
    vs   = !(in_r && v >= 490 && v < 492);
    von  = in_r && h < 640 && v < 480;
    px   = von ? 10'(h) : 10'd0;
    py   = von ? 10'(v) : 10'd0;
    ls   = in_r && h == 0;
    fs   = ls && v == 0;
    return {hs, vs, von, px, py, ls, fs, err};
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp = BLANK;
  int           m_prev_h;
  int           m_prev_v;
  bit           m_prev_valid = 0;
  logic         m_err = 1'b0;

  always @(posedge clk_25Hz or negedge reset_n) begin
    if (!reset_n) begin
      m_prev_valid = 0;
      m_err        = 1'b0;
      exp_q.delete();
      for (int i = 0; i < PD - 1; i++) exp_q.push_back(BLANK);
      cur_exp = BLANK;
    end else begin
      int  h;
      int  v;
      bit  bad;
      h   = int'(h_count);
      v   = int'(v_count);
      bad = (h >= HT) || (v >= VT);
      if (m_prev_valid) begin
        if (h != (m_prev_h + 1) % HT) bad = 1;
        if (v != m_prev_v && (m_prev_h != HT - 1 || v != (m_prev_v + 1) % VT)) bad = 1;
        if (enable_v_counter && h != HT - 1) bad = 1;
      end
      m_err = m_err | bad;
      exp_q.push_back(model_out(h, v, m_err));
      cur_exp      = exp_q.pop_front();
      m_prev_h     = h;
      m_prev_v     = v;
      m_prev_valid = 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare, every falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk_25Hz) begin
    logic [W-1:0] act;
    act = {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, count_error};
    checks++;
    if (act !== cur_exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: dut=%h model=%h", $time, act, cur_exp);
    end
  end

  // Aggregate counters over a monitored window
  bit mon_en = 0;
  int mon_hs_low, mon_vs_low, mon_von, mon_ls, mon_fs, mon_err;

  always @(negedge clk_25Hz) begin
    if (mon_en) begin
      if (!hsync)      mon_hs_low++;
      if (!vsync)      mon_vs_low++;
      if (video_on)    mon_von++;
      if (line_start)  mon_ls++;
      if (frame_start) mon_fs++;
      if (count_error) mon_err++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int h, input int v);
    h_count          = 16'(h);
    v_count          = 16'(v);
    enable_v_counter = (h == HT - 1);
    @(posedge clk_25Hz);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_25Hz);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held with clocks running
    reset_n = 1'b0;
    repeat (4) step(123, 45);
    check_val("rst_hsync", int'(hsync), 1);
    check_val("rst_vsync", int'(vsync), 1);
    check_val("rst_video_on", int'(video_on), 0);
    check_val("rst_count_error", int'(count_error), 0);
    reset_n = 1'b1;
    step(0, 0);
    check_val("latency_not_yet", int'(frame_start), 0);
    step(1, 0);
    check_val("latency_frame_start", int'(frame_start), 1);
    check_val("latency_video_on", int'(video_on), 1);
    step(2, 0);
    check_val("latency_px1", int'(pixel_x), 1);

    // Ideal counter across lines 478..524,0..2 (frame wrap inside)
    apply_reset();
    mon_hs_low = 0; mon_vs_low = 0; mon_von = 0; mon_ls = 0; mon_fs = 0; mon_err = 0;
    for (int idx = 0; idx <= 50 * HT + PD - 2; idx++) begin
      step(idx % HT, (478 + idx / HT) % VT);
      mon_en = (idx >= PD - 1);
      if (idx == 47 * HT + PD - 1) begin
        check_val("corner_line_start", int'(line_start), 1);
        check_val("corner_frame_start", int'(frame_start), 1);
        check_val("corner_video_on", int'(video_on), 1);
        check_val("corner_pixel_x", int'(pixel_x), 0);
        check_val("corner_pixel_y", int'(pixel_y), 0);
      end
      if (idx == 47 * HT + PD) begin
        check_val("corner_frame_start_1clk", int'(frame_start), 0);
        check_val("corner_line_start_1clk", int'(line_start), 0);
      end
    end
    @(negedge clk_25Hz);
    #1;
    mon_en = 0;
    check_val("frame_hsync_low_clks", mon_hs_low, 50 * 96);
    check_val("frame_vsync_low_clks", mon_vs_low, 2 * HT);
    check_val("frame_video_on_clks", mon_von, 5 * 640);
    check_val("frame_line_starts", mon_ls, 50);
    check_val("frame_frame_starts", mon_fs, 1);
    check_val("frame_error_clks", mon_err, 0);

    // h_count jump 100 -> 102
    apply_reset();
    for (int h = 90; h <= 100; h++) step(h, 100);
    step(102, 100);
    check_val("jump_err_before", int'(count_error), 0);
    step(103, 100);
    check_val("jump_err_set", int'(count_error), 1);
    for (int h = 104; h < HT; h++) step(h, 100);
    for (int h = 0; h <= 50; h++) step(h, 101);
    check_val("jump_err_sticky", int'(count_error), 1);

    // v_count out of range
    apply_reset();
    for (int h = 790; h < HT; h++) step(h, 100);
    step(0, 600);
    check_val("vrange_err_before", int'(count_error), 0);
    step(1, 600);
    check_val("vrange_err", int'(count_error), 1);
    check_val("vrange_vsync", int'(vsync), 1);
    check_val("vrange_hsync", int'(hsync), 1);
    check_val("vrange_video_on", int'(video_on), 0);
    check_val("vrange_line_start", int'(line_start), 0);
    check_val("vrange_frame_start", int'(frame_start), 0);
    for (int h = 2; h <= 20; h++) step(h, 600);

    // Reset mid-frame at h=300, release with h=311 the first sample
    apply_reset();
    for (int h = 290; h <= 300; h++) step(h, 200);
    check_val("mid_pre_video_on", int'(video_on), 1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_video_on", int'(video_on), 0);
    check_val("mid_rst_pixel_x", int'(pixel_x), 0);
    check_val("mid_rst_hsync", int'(hsync), 1);
    for (int h = 301; h <= 310; h++) step(h, 200);
    reset_n = 1'b1;
    step(311, 200);
    check_val("mid_refill_blank", int'(video_on), 0);
    step(312, 200);
    check_val("mid_refill_video_on", int'(video_on), 1);
    check_val("mid_refill_pixel_x", int'(pixel_x), 311);
    check_val("mid_refill_pixel_y", int'(pixel_y), 200);
    check_val("mid_refill_err", int'(count_error), 0);
    for (int h = 313; h < HT; h++) step(h, 200);
    for (int h = 0; h <= 20; h++) step(h, 201);
    check_val("mid_no_err", int'(count_error), 0);

    @(negedge clk_25Hz);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
